// File: rtl/router_ingress_ctrl.sv
// Ingress controller of the 1x3 router: decodes packet headers, steers bytes into the
// selected output FIFO with full/empty flow control, and checks parity and length.
module router_ingress_ctrl #(
    parameter int PORTS = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [7:0]       data_in,
    output logic             busy,
    input  logic [PORTS-1:0] fifo_full,
    input  logic [PORTS-1:0] fifo_empty,
    input  logic [PORTS-1:0] soft_reset,
    output logic [PORTS-1:0] write_enb,
    output logic             lfd_state,
    output logic [7:0]       data_out,
    output logic             err,
    output logic             len_err
);

    typedef enum logic [2:0] {
        DECODE,
        DROP,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        PARITY_DONE
    } state_t;

    state_t      state;
    logic [1:0]  addr;
    logic [7:0]  hdr;
    logic [7:0]  parity;
    logic [7:0]  parity_byte;
    logic [5:0]  count;
    logic        wr_pending;

    logic        full_sel;
    logic        empty_sel;
    logic        srst_sel;
    logic        hdr_empty;
    logic        hdr_ok;
    logic        wr_fire;
    logic        accept;
    logic        in_packet;

    // Per-port flag lookup; addresses beyond PORTS read as 0.
    function automatic logic pick(input logic [PORTS-1:0] v, input logic [1:0] idx);
        pick = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (idx == 2'(i)) pick = v[i];
        end
    endfunction

    always_comb begin
        full_sel  = pick(fifo_full, addr);
        empty_sel = pick(fifo_empty, addr);
        srst_sel  = pick(soft_reset, addr);
        hdr_empty = pick(fifo_empty, data_in[1:0]);
        hdr_ok    = int'(data_in[1:0]) < PORTS;
        wr_fire   = wr_pending & ~full_sel;
        busy      = (state == WAIT_EMPTY) || (state == LOAD_FIRST) ||
                    (state == PARITY_DONE) || (wr_pending && full_sel);
        accept    = !busy && ((state == DECODE && pkt_valid) ||
                              (state == DROP) || (state == LOAD_DATA));
        in_packet = (state == WAIT_EMPTY) || (state == LOAD_FIRST) ||
                    (state == LOAD_DATA) || (state == PARITY_DONE);
        for (int i = 0; i < PORTS; i++) begin
            write_enb[i] = wr_pending && (addr == 2'(i)) && !fifo_full[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= DECODE;
            addr        <= 2'd0;
            hdr         <= 8'd0;
            parity      <= 8'd0;
            parity_byte <= 8'd0;
            count       <= 6'd0;
            wr_pending  <= 1'b0;
            data_out    <= 8'd0;
            lfd_state   <= 1'b0;
            err         <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            lfd_state <= 1'b0;
            if (wr_fire) wr_pending <= 1'b0;

            // Soft reset of the active port abandons the packet; flags keep their value.
            if (in_packet && srst_sel) begin
                state      <= DECODE;
                wr_pending <= 1'b0;
            end else begin
                case (state)
                    DECODE: begin
                        if (accept) begin
                            if (!hdr_ok) begin
                                state <= DROP;
                            end else begin
                                addr    <= data_in[1:0];
                                hdr     <= data_in;
                                parity  <= data_in;
                                count   <= 6'd0;
                                err     <= 1'b0;
                                len_err <= 1'b0;
                                if (hdr_empty) begin
                                    state     <= LOAD_FIRST;
                                    lfd_state <= 1'b1;
                                end else begin
                                    state <= WAIT_EMPTY;
                                end
                            end
                        end
                    end
                    DROP: begin
                        if (accept && !pkt_valid) state <= DECODE;
                    end
                    WAIT_EMPTY: begin
                        if (empty_sel) begin
                            state     <= LOAD_FIRST;
                            lfd_state <= 1'b1;
                        end
                    end
                    LOAD_FIRST: begin
                        data_out   <= hdr;
                        wr_pending <= 1'b1;
                        state      <= LOAD_DATA;
                    end
                    LOAD_DATA: begin
                        // busy=0 here guarantees any previous pending byte is written this edge.
                        if (accept) begin
                            data_out   <= data_in;
                            wr_pending <= 1'b1;
                            if (pkt_valid) begin
                                parity <= parity ^ data_in;
                                count  <= count + 6'd1;
                            end else begin
                                parity_byte <= data_in;
                                state       <= PARITY_DONE;
                            end
                        end
                    end
                    PARITY_DONE: begin
                        if (!wr_pending || wr_fire) begin
                            err     <= (parity != parity_byte);
                            len_err <= (count != hdr[7:2]);
                            state   <= DECODE;
                        end
                    end
                    default: state <= DECODE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Scoreboard bench for router_ingress_ctrl: stimulus pushes expected FIFO writes,
// a negedge monitor pops and compares every write, plus directed cycle checks.
module tb_router_ingress_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       busy;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] soft_reset = 3'b000;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [7:0] data_out;
    logic       err;
    logic       len_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] we;
        logic [7:0] data;
        logic       first;
    } exp_t;

    exp_t       exp_q[$];
    logic       prev_lfd = 1'b0;
    logic [7:0] pl [0:7];

    // Directed packet 0D/11/22/33/0D, one row per cycle c0..c7.
    logic       t1_v    [0:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] t1_d    [0:7] = '{8'h0D, 8'h11, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h0D, 8'h00};
    logic       t1_busy [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t1_lfd  [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    router_ingress_ctrl #(.PORTS(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_out   (data_out),
        .err        (err),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] port, input logic [7:0] d, input logic first);
        exp_t e;
        e.we    = 3'(1) << port;
        e.data  = d;
        e.first = first;
        exp_q.push_back(e);
    endtask

    // Monitor: every FIFO write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (resetn && write_enb != 3'b000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0b/%0h required=none at %0t",
                         write_enb, data_out, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_port", 32'(write_enb), 32'(e.we));
                chk("wr_data", 32'(data_out), 32'(e.data));
                chk("wr_lfd_before", 32'(prev_lfd), 32'(e.first));
            end
        end
        prev_lfd = lfd_state;
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input logic v, output int stalls);
        pkt_valid = v;
        data_in   = b;
        stalls    = 0;
        #2;
        while (busy && stalls < 100) begin
            @(negedge clk);
            #2;
            stalls++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=busy required=accept byte=%0h", b);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        #2;
        while (busy && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic run_packet(input logic [7:0] h, input int n, input logic [7:0] par);
        int         s;
        logic [7:0] p;
        logic       valid;
        valid = (h[1:0] != 2'd3);
        p = h;
        for (int i = 0; i < n; i++) p = p ^ pl[i];
        if (valid) begin
            push_exp(h[1:0], h, 1'b1);
            for (int i = 0; i < n; i++) push_exp(h[1:0], pl[i], 1'b0);
            push_exp(h[1:0], par, 1'b0);
        end
        send_byte(h, 1'b1, s);
        if (!valid) chk("drop_hdr_stall", 32'(s), 32'd0);
        for (int i = 0; i < n; i++) begin
            send_byte(pl[i], 1'b1, s);
            if (!valid) chk("drop_byte_stall", 32'(s), 32'd0);
        end
        send_byte(par, 1'b0, s);
        if (valid) begin
            wait_idle();
            chk("pkt_err", 32'(err), 32'(p != par));
            chk("pkt_len_err", 32'(len_err), 32'(n[5:0] != h[7:2]));
            chk("pkt_all_written", 32'(exp_q.size()), 32'd0);
        end else begin
            #2;
            chk("drop_busy_after", 32'(busy), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write_enb", 32'(write_enb), 32'd0);
        chk("rst_lfd", 32'(lfd_state), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Cycle-exact good packet to port 1
        push_exp(2'd1, 8'h0D, 1'b1);
        push_exp(2'd1, 8'h11, 1'b0);
        push_exp(2'd1, 8'h22, 1'b0);
        push_exp(2'd1, 8'h33, 1'b0);
        push_exp(2'd1, 8'h0D, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pkt_valid = t1_v[i];
            data_in   = t1_d[i];
            #2;
            chk($sformatf("t1_busy_c%0d", i), 32'(busy), 32'(t1_busy[i]));
            chk($sformatf("t1_lfd_c%0d", i), 32'(lfd_state), 32'(t1_lfd[i]));
            @(negedge clk);
        end
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_len_err", 32'(len_err), 32'd0);
        chk("t1_all_written", 32'(exp_q.size()), 32'd0);

        // Bad parity, flag held afterwards
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        run_packet(8'h0D, 3, 8'h0E);
        repeat (3) @(negedge clk);
        chk("t2_err_held", 32'(err), 32'd1);

        // FIFO 1 full for three cycles mid-payload
        fork
            run_packet(8'h0D, 3, 8'h0D);
            begin
                repeat (3) @(negedge clk);
                fifo_full[1] = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #2;
                    chk("stall_busy", 32'(busy), 32'd1);
                    chk("stall_data_held", 32'(data_out), 32'h11);
                    @(negedge clk);
                end
                fifo_full[1] = 1'b0;
            end
        join

        // Invalid address 3 is dropped, then a normal packet to port 0
        pl[0] = 8'hC3; pl[1] = 8'h3C;
        run_packet(8'h0B, 2, 8'h0B);
        pl[0] = 8'hAA; pl[1] = 8'h55;
        run_packet(8'h08, 2, 8'hF7);

        // Port 2 not empty for four cycles
        push_exp(2'd2, 8'h06, 1'b1);
        push_exp(2'd2, 8'h5A, 1'b0);
        push_exp(2'd2, 8'h5C, 1'b0);
        fifo_empty[2] = 1'b0;
        send_byte(8'h06, 1'b1, s);
        data_in = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_lfd", 32'(lfd_state), 32'd0);
            @(negedge clk);
        end
        fifo_empty[2] = 1'b1;
        #2;
        chk("wait_rise_busy", 32'(busy), 32'd1);
        chk("wait_rise_lfd", 32'(lfd_state), 32'd0);
        @(negedge clk);
        #2;
        chk("wait_lfd_next", 32'(lfd_state), 32'd1);
        @(negedge clk);
        send_byte(8'h5A, 1'b1, s);
        send_byte(8'h5C, 1'b0, s);
        wait_idle();
        chk("wait_err", 32'(err), 32'd0);
        chk("wait_len_err", 32'(len_err), 32'd0);
        @(negedge clk);

        // Soft reset of port 0 during payload
        push_exp(2'd0, 8'h10, 1'b1);
        push_exp(2'd0, 8'hA1, 1'b0);
        send_byte(8'h10, 1'b1, s);
        send_byte(8'hA1, 1'b1, s);
        soft_reset[0] = 1'b1;
        data_in = 8'hA2;
        @(negedge clk);
        soft_reset[0] = 1'b0;
        pkt_valid = 1'b0;
        #2;
        chk("srst_write_enb", 32'(write_enb), 32'd0);
        chk("srst_busy", 32'(busy), 32'd0);
        chk("srst_all_written", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // Length errors, then zero-length packet
        pl[0] = 8'h01; pl[1] = 8'h02;
        run_packet(8'h05, 2, 8'h06);
        run_packet(8'h05, 2, 8'h07);
        run_packet(8'h02, 0, 8'h02);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
